// File: rtl/roce_minimal_stack_64.sv
// roce_minimal_stack_64
//   RoCEv2 RDMA WRITE transmit generator. A start pulse latches a transfer description; the
//   transfer is split into PMTU-sized RC WRITE packets (ONLY, or FIRST/MIDDLE.../LAST). Each
//   packet is presented as a UDP header handshake followed by a 64-bit AXI-Stream UDP payload
//   carrying BTH, RETH (first/only packet), test-pattern data and a zero-filled ICRC.
//
//   Optional feature macro: ROCE_ACK_REQ_EN
//     defined   -> BTH AckReq set on LAST and ONLY packets
//     undefined -> BTH AckReq always 0
//
//   Ports
//     clk, rst                        clock, asynchronous active-high reset
//     dma_transfer_length             total bytes to write
//     rem_qpn, rem_psn                destination QP, starting PSN
//     r_key, rem_addr                 remote key, remote virtual address
//     rem_ip_addr                     destination IP address
//     start_transfer                  start request, sampled while idle
//     m_udp_hdr_*                     UDP/IP/Ethernet header fields with valid/ready
//     m_udp_payload_axis_*            64-bit UDP payload stream
//     busy                            transfer in progress
//     error_payload_early_termination one-cycle pulse: start seen while busy (dropped)

module roce_minimal_stack_64 #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          PMTU         = 1024,
  parameter logic [31:0] LOCAL_IP     = 32'h0BD40174,
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] UDP_SRC_PORT = 16'hC000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dma_transfer_length,
  input  logic [23:0]               rem_qpn,
  input  logic [23:0]               rem_psn,
  input  logic [31:0]               r_key,
  input  logic [47:0]               rem_addr,
  input  logic [31:0]               rem_ip_addr,
  input  logic                      start_transfer,
  output logic                      m_udp_hdr_valid,
  input  logic                      m_udp_hdr_ready,
  output logic [47:0]               m_eth_dest_mac,
  output logic [47:0]               m_eth_src_mac,
  output logic [15:0]               m_eth_type,
  output logic [3:0]                m_ip_version,
  output logic [3:0]                m_ip_ihl,
  output logic [5:0]                m_ip_dscp,
  output logic [1:0]                m_ip_ecn,
  output logic [15:0]               m_ip_length,
  output logic [15:0]               m_ip_identification,
  output logic [2:0]                m_ip_flags,
  output logic [12:0]               m_ip_fragment_offset,
  output logic [7:0]                m_ip_ttl,
  output logic [7:0]                m_ip_protocol,
  output logic [15:0]               m_ip_header_checksum,
  output logic [31:0]               m_ip_source_ip,
  output logic [31:0]               m_ip_dest_ip,
  output logic [15:0]               m_udp_source_port,
  output logic [15:0]               m_udp_dest_port,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic [DATA_WIDTH-1:0]     m_udp_payload_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_udp_payload_axis_tkeep,
  output logic                      m_udp_payload_axis_tvalid,
  input  logic                      m_udp_payload_axis_tready,
  output logic                      m_udp_payload_axis_tlast,
  output logic                      m_udp_payload_axis_tuser,
  output logic                      busy,
  output logic                      error_payload_early_termination
);

  localparam logic [31:0] PmtuLen  = 32'(PMTU);
  localparam logic [7:0]  OpFirst  = 8'h06;
  localparam logic [7:0]  OpMiddle = 8'h07;
  localparam logic [7:0]  OpLast   = 8'h08;
  localparam logic [7:0]  OpOnly   = 8'h0A;

  typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_t;

  state_t r_state;
  state_t w_state_next;

  // Transfer description latched on start
  logic [31:0] r_len;
  logic [23:0] r_qpn;
  logic [23:0] r_psn;
  logic [31:0] r_rkey;
  logic [47:0] r_addr;
  logic [31:0] r_dst_ip;

  // Progress counters
  logic [31:0] r_remaining;  // bytes not yet sent, including the current packet
  logic [7:0]  r_offset;     // global data offset of the current packet (only the low byte matters)
  logic [23:0] r_pkt_idx;
  logic [10:0] r_word;
  logic        r_err;

  logic         w_first;
  logic         w_last_pkt;
  logic [12:0]  w_pay;
  logic [5:0]   w_hl;
  logic [13:0]  w_total;
  logic [13:0]  w_total_m1;
  logic [10:0]  w_last_idx;
  logic         w_last_word;
  logic [3:0]   w_tail;
  logic [8:0]   w_keep_ext;
  logic [7:0]   w_opcode;
  logic         w_ack;
  logic [23:0]  w_psn;
  logic [223:0] w_hdr_bytes;
  logic [7:0]   w_hdr_arr [32];
  logic         w_beat;

  // ---------------------------------------------------------------------------------------------
  // Per-packet geometry, stable for the whole packet
  // ---------------------------------------------------------------------------------------------
  assign w_first     = (r_pkt_idx == 24'd0);
  assign w_last_pkt  = (r_remaining <= PmtuLen);
  assign w_pay       = w_last_pkt ? r_remaining[12:0] : PmtuLen[12:0];
  assign w_hl        = w_first ? 6'd28 : 6'd12;
  assign w_total     = 14'(w_pay) + 14'(w_hl) + 14'd4;
  assign w_total_m1  = w_total - 14'd1;
  assign w_last_idx  = w_total_m1[13:3];
  assign w_last_word = (r_word == w_last_idx);
  // Valid bytes on the final word: 1..8, packed from lane 0
  assign w_tail      = {1'b0, w_total_m1[2:0]} + 4'd1;
  assign w_keep_ext  = (9'd1 << w_tail) - 9'd1;
  assign w_psn       = r_psn + r_pkt_idx;
  assign w_beat      = (r_state == StPayload) && m_udp_payload_axis_tready;

  always_comb begin
    w_opcode = OpMiddle;
    if (w_first && w_last_pkt) begin
      w_opcode = OpOnly;
    end else if (w_first) begin
      w_opcode = OpFirst;
    end else if (w_last_pkt) begin
      w_opcode = OpLast;
    end
  end

`ifdef ROCE_ACK_REQ_EN
  assign w_ack = w_last_pkt;
`else
  assign w_ack = 1'b0;
`endif

  // BTH (12 bytes) followed by RETH (16 bytes), first byte in the top octet
  assign w_hdr_bytes = {w_opcode, 8'h00, 16'hFFFF, 8'h00, r_qpn, {w_ack, 7'h00}, w_psn,
                        16'h0000, r_addr, r_rkey, r_len};

  always_comb begin
    for (int i = 0; i < 28; i++) begin
      w_hdr_arr[i] = w_hdr_bytes[8*(27-i) +: 8];
    end
    for (int i = 28; i < 32; i++) begin
      w_hdr_arr[i] = 8'h00;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Payload lanes: stream byte k = 8*word + lane
  // ---------------------------------------------------------------------------------------------
  always_comb begin : p_lanes
    logic [13:0] v_k;
    v_k = '0;
    m_udp_payload_axis_tdata = '0;
    for (int j = 0; j < 8; j++) begin
      v_k = {r_word, 3'(j)};
      if (v_k < 14'(w_hl)) begin
        m_udp_payload_axis_tdata[8*j +: 8] = w_hdr_arr[v_k[4:0]];
      end else if (v_k < (14'(w_hl) + 14'(w_pay))) begin
        m_udp_payload_axis_tdata[8*j +: 8] = r_offset + v_k[7:0] - {2'b00, w_hl};
      end
      // ICRC bytes and bytes past the end stay zero
    end
  end

  assign m_udp_payload_axis_tkeep = w_last_word ? w_keep_ext[7:0] : 8'hFF;
  assign m_udp_payload_axis_tuser = 1'b0;

  // ---------------------------------------------------------------------------------------------
  // Header fields
  // ---------------------------------------------------------------------------------------------
  assign m_eth_dest_mac       = 48'h0;
  assign m_eth_src_mac        = LOCAL_MAC;
  assign m_eth_type           = 16'h0800;
  assign m_ip_version         = 4'd4;
  assign m_ip_ihl             = 4'd5;
  assign m_ip_dscp            = 6'd0;
  assign m_ip_ecn             = 2'd0;
  assign m_ip_identification  = 16'd0;
  assign m_ip_flags           = 3'b010;
  assign m_ip_fragment_offset = 13'd0;
  assign m_ip_ttl             = 8'd64;
  assign m_ip_protocol        = 8'h11;
  assign m_ip_header_checksum = 16'h0;
  assign m_ip_source_ip       = LOCAL_IP;
  assign m_ip_dest_ip         = r_dst_ip;
  assign m_udp_source_port    = UDP_SRC_PORT;
  assign m_udp_dest_port      = 16'd4791;
  assign m_udp_checksum       = 16'h0;
  assign m_udp_length         = 16'(w_total) + 16'd8;
  assign m_ip_length          = 16'(w_total) + 16'd28;

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next              = r_state;
    m_udp_hdr_valid           = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    busy                      = 1'b1;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start_transfer) begin
          w_state_next = StHdr;
        end
      end
      StHdr: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) begin
          w_state_next = StPayload;
        end
      end
      StPayload: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tlast  = w_last_word;
        if (w_beat && w_last_word) begin
          w_state_next = w_last_pkt ? StIdle : StHdr;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Latches and counters
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_qpn       <= '0;
      r_psn       <= '0;
      r_rkey      <= '0;
      r_addr      <= '0;
      r_dst_ip    <= '0;
      r_remaining <= '0;
      r_offset    <= '0;
      r_pkt_idx   <= '0;
      r_word      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state != StIdle) && start_transfer;
      if ((r_state == StIdle) && start_transfer) begin
        r_len       <= dma_transfer_length;
        r_qpn       <= rem_qpn;
        r_psn       <= rem_psn;
        r_rkey      <= r_key;
        r_addr      <= rem_addr;
        r_dst_ip    <= rem_ip_addr;
        r_remaining <= dma_transfer_length;
        r_offset    <= '0;
        r_pkt_idx   <= '0;
        r_word      <= '0;
      end else if (w_beat) begin
        if (w_last_word) begin
          r_word      <= '0;
          r_remaining <= r_remaining - 32'(w_pay);
          r_offset    <= r_offset + w_pay[7:0];
          r_pkt_idx   <= r_pkt_idx + 24'd1;
        end else begin
          r_word <= r_word + 11'd1;
        end
      end
    end
  end

  assign error_payload_early_termination = r_err;

endmodule

// File: tb/tb_roce_minimal_stack_64.sv
// Directed bench for roce_minimal_stack_64: segmentation, header fields, payload bytes,
// backpressure, busy-start error pulse, PSN wrap, partial final words and async reset.
module tb_roce_minimal_stack_64;

`ifdef ROCE_ACK_REQ_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dma_transfer_length;
  logic [23:0] rem_qpn, rem_psn;
  logic [31:0] r_key;
  logic [47:0] rem_addr;
  logic [31:0] rem_ip_addr;
  logic        start_transfer;
  logic        m_udp_hdr_valid, m_udp_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [3:0]  m_ip_version, m_ip_ihl;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [15:0] m_ip_length, m_ip_identification;
  logic [2:0]  m_ip_flags;
  logic [12:0] m_ip_fragment_offset;
  logic [7:0]  m_ip_ttl, m_ip_protocol;
  logic [15:0] m_ip_header_checksum;
  logic [31:0] m_ip_source_ip, m_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast, tuser;
  logic        busy, err;

  always #5 clk = ~clk;

  roce_minimal_stack_64 dut (
    .clk                             (clk),
    .rst                             (rst),
    .dma_transfer_length             (dma_transfer_length),
    .rem_qpn                         (rem_qpn),
    .rem_psn                         (rem_psn),
    .r_key                           (r_key),
    .rem_addr                        (rem_addr),
    .rem_ip_addr                     (rem_ip_addr),
    .start_transfer                  (start_transfer),
    .m_udp_hdr_valid                 (m_udp_hdr_valid),
    .m_udp_hdr_ready                 (m_udp_hdr_ready),
    .m_eth_dest_mac                  (m_eth_dest_mac),
    .m_eth_src_mac                   (m_eth_src_mac),
    .m_eth_type                      (m_eth_type),
    .m_ip_version                    (m_ip_version),
    .m_ip_ihl                        (m_ip_ihl),
    .m_ip_dscp                       (m_ip_dscp),
    .m_ip_ecn                        (m_ip_ecn),
    .m_ip_length                     (m_ip_length),
    .m_ip_identification             (m_ip_identification),
    .m_ip_flags                      (m_ip_flags),
    .m_ip_fragment_offset            (m_ip_fragment_offset),
    .m_ip_ttl                        (m_ip_ttl),
    .m_ip_protocol                   (m_ip_protocol),
    .m_ip_header_checksum            (m_ip_header_checksum),
    .m_ip_source_ip                  (m_ip_source_ip),
    .m_ip_dest_ip                    (m_ip_dest_ip),
    .m_udp_source_port               (m_udp_source_port),
    .m_udp_dest_port                 (m_udp_dest_port),
    .m_udp_length                    (m_udp_length),
    .m_udp_checksum                  (m_udp_checksum),
    .m_udp_payload_axis_tdata        (tdata),
    .m_udp_payload_axis_tkeep        (tkeep),
    .m_udp_payload_axis_tvalid       (tvalid),
    .m_udp_payload_axis_tready       (tready),
    .m_udp_payload_axis_tlast        (tlast),
    .m_udp_payload_axis_tuser        (tuser),
    .busy                            (busy),
    .error_payload_early_termination (err)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  g_bytes[$];
  int          g_beats, g_tuser_cnt, g_proto_bad, g_pat_idx, g_pkt_num;
  int          g_err_pkt = -1;
  bit          g_use_pat = 1'b0;
  logic [7:0]  g_last_keep;
  logic [15:0] g_udp_len, g_ip_len;
  logic [31:0] g_dst_ip;
  bit          pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
  endtask

  task automatic start(input logic [31:0] len, input logic [23:0] psn, input logic [23:0] qpn);
    dma_transfer_length = len;
    rem_psn             = psn;
    rem_qpn             = qpn;
    start_transfer      = 1'b1;
    @(posedge clk); #1;
    start_transfer = 1'b0;
    g_pkt_num      = 0;
    g_pat_idx      = 0;
    check("busy_after_start", busy, 1'b1);
    check("hdr_valid_after_start", m_udp_hdr_valid, 1'b1);
  endtask

  // Receive one packet: header handshake (optionally held off), then payload beats.
  task automatic recv_packet(input int hold, input bit chk_hdr);
    int         cyc;
    bit         done;
    bit         prev_stall;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    g_bytes.delete();
    g_beats = 0; g_tuser_cnt = 0; g_proto_bad = 0;
    cyc = 0;
    while (!m_udp_hdr_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hdr_valid_seen", m_udp_hdr_valid, 1'b1);
    if (!m_udp_hdr_valid) return;
    g_udp_len = m_udp_length;
    g_ip_len  = m_ip_length;
    g_dst_ip  = m_ip_dest_ip;
    if (chk_hdr) begin
      check("eth_dest_mac", m_eth_dest_mac, 48'h0);
      check("eth_src_mac", m_eth_src_mac, 48'h020000000001);
      check("eth_type", m_eth_type, 16'h0800);
      check("ip_ver_ihl_dscp_ecn", {m_ip_version, m_ip_ihl, m_ip_dscp, m_ip_ecn}, 16'h4500);
      check("ip_id_flags_frag", {m_ip_identification, m_ip_flags, m_ip_fragment_offset},
            32'h0000_4000);
      check("ip_ttl_proto_csum", {m_ip_ttl, m_ip_protocol, m_ip_header_checksum}, 32'h4011_0000);
      check("ip_src", m_ip_source_ip, 32'h0BD40174);
      check("udp_ports_csum", {m_udp_source_port, m_udp_dest_port, m_udp_checksum},
            48'hC000_12B7_0000);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      if (!m_udp_hdr_valid || m_udp_length !== g_udp_len || m_ip_dest_ip !== g_dst_ip)
        g_proto_bad++;
    end
    m_udp_hdr_ready = 1'b1;
    @(posedge clk); #1;
    m_udp_hdr_ready = 1'b0;
    cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_keep = '0;
    while (!done && cyc < 3000) begin
      tready = g_use_pat ? pat[g_pat_idx % 8] : 1'b1;
      g_pat_idx++;
      if (!tvalid) g_proto_bad++;
      if (prev_stall && (tdata !== prev_data || tkeep !== prev_keep)) g_proto_bad++;
      if (g_pkt_num == g_err_pkt && cyc == 5) start_transfer = 1'b1;
      if (tvalid && tready) begin
        for (int j = 0; j < 8; j++) if (tkeep[j]) g_bytes.push_back(tdata[8*j +: 8]);
        g_beats++;
        if (tuser) g_tuser_cnt++;
        if (tlast) begin
          g_last_keep = tkeep;
          done        = 1'b1;
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      @(posedge clk); #1;
      if (start_transfer) begin
        start_transfer = 1'b0;
        check("err_pulse_high", err, 1'b1);
      end else if (g_pkt_num == g_err_pkt && cyc == 6) begin
        check("err_pulse_low", err, 1'b0);
      end
      cyc++;
    end
    tready = 1'b0;
    check("pkt_done", done, 1'b1);
    g_pkt_num++;
  endtask

  task automatic chk_pkt(input string tag, input logic [7:0] op, input int udp,
                         input logic [23:0] psn, input logic [23:0] qpn, input bit is_last,
                         input int off, input int beats, input logic [7:0] keep,
                         input logic [31:0] dlen);
    int hl, pay, bad;
    hl  = (op == 8'h06 || op == 8'h0A) ? 28 : 12;
    pay = udp - 8 - hl - 4;
    bad = 0;
    check({tag, ".udp_len"}, g_udp_len, 16'(udp));
    check({tag, ".ip_len"}, g_ip_len, 16'(udp + 20));
    check({tag, ".ip_dst"}, g_dst_ip, rem_ip_addr);
    check({tag, ".nbytes"}, g_bytes.size(), udp - 8);
    check({tag, ".beats"}, g_beats, beats);
    check({tag, ".last_keep"}, g_last_keep, keep);
    check({tag, ".bth0_3"}, {g_bytes[0], g_bytes[1], g_bytes[2], g_bytes[3]},
          {op, 8'h00, 16'hFFFF});
    check({tag, ".bth4_7"}, {g_bytes[4], g_bytes[5], g_bytes[6], g_bytes[7]}, {8'h00, qpn});
    check({tag, ".bth8_11"}, {g_bytes[8], g_bytes[9], g_bytes[10], g_bytes[11]},
          {(AckEn && is_last) ? 8'h80 : 8'h00, psn});
    if (hl == 28) begin
      check({tag, ".reth_va"}, {g_bytes[12], g_bytes[13], g_bytes[14], g_bytes[15],
                                g_bytes[16], g_bytes[17], g_bytes[18], g_bytes[19]},
            {16'h0, rem_addr});
      check({tag, ".reth_rkey"}, {g_bytes[20], g_bytes[21], g_bytes[22], g_bytes[23]}, r_key);
      check({tag, ".reth_len"}, {g_bytes[24], g_bytes[25], g_bytes[26], g_bytes[27]}, dlen);
    end
    for (int i = 0; i < pay; i++) if (g_bytes[hl + i] !== 8'(off + i)) bad++;
    check({tag, ".data_bad"}, bad, 0);
    check({tag, ".icrc"}, {g_bytes[hl+pay], g_bytes[hl+pay+1], g_bytes[hl+pay+2],
                           g_bytes[hl+pay+3]}, 32'h0);
    check({tag, ".protocol_bad"}, g_proto_bad, 0);
    check({tag, ".tuser"}, g_tuser_cnt, 0);
  endtask

  initial begin
    int off;
    rst = 1'b1;
    dma_transfer_length = '0; rem_qpn = '0; rem_psn = '0; r_key = 32'hDEFE;
    rem_addr = 48'h1234_5678_9ABC; rem_ip_addr = 32'h0BD40116;
    start_transfer = 1'b0; m_udp_hdr_ready = 1'b0; tready = 1'b0;
    #1;
    check("reset_hdr_valid", m_udp_hdr_valid, 1'b0);
    check("reset_tvalid", tvalid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 16400 bytes: FIRST + 15 MIDDLE + LAST(16 B), backpressure, stray start in packet 3
    g_use_pat = 1'b1;
    g_err_pkt = 3;
    off       = 0;
    start(32'd16400, 24'd302, 24'h16);
    for (int p = 0; p < 17; p++) begin
      recv_packet((p == 0) ? 2 : 0, p == 0);
      if (p == 0) begin
        chk_pkt("first", 8'h06, 1064, 24'(302 + p), 24'h16, 1'b0, off, 132, 8'hFF, 32'd16400);
        check("byte_at_300", g_bytes[28 + 300], 8'h2C);
        off += 1024;
      end else if (p < 16) begin
        chk_pkt($sformatf("middle%0d", p), 8'h07, 1048, 24'(302 + p), 24'h16, 1'b0, off, 130,
                8'hFF, 32'd0);
        off += 1024;
      end else begin
        chk_pkt("last", 8'h08, 40, 24'(302 + p), 24'h16, 1'b1, off, 4, 8'hFF, 32'd0);
      end
    end
    check("busy_after_done", busy, 1'b0);
    check("hdr_valid_after_done", m_udp_hdr_valid, 1'b0);
    g_use_pat = 1'b0;
    g_err_pkt = -1;

    // 512 bytes: single ONLY packet, 68 full words
    rem_ip_addr = 32'h0A00_0002;
    start(32'd512, 24'd1000, 24'h00ABCD);
    recv_packet(0, 1'b0);
    chk_pkt("only512", 8'h0A, 552, 24'd1000, 24'h00ABCD, 1'b1, 0, 68, 8'hFF, 32'd512);
    check("busy_after_only512", busy, 1'b0);

    // 0 bytes: ONLY packet with headers and ICRC only
    start(32'd0, 24'd7, 24'h1);
    recv_packet(0, 1'b0);
    chk_pkt("only0", 8'h0A, 40, 24'd7, 24'h1, 1'b1, 0, 4, 8'hFF, 32'd0);

    // 5 bytes: 37-byte payload, final word carries 5 bytes
    start(32'd5, 24'd9, 24'h2);
    recv_packet(0, 1'b0);
    chk_pkt("only5", 8'h0A, 45, 24'd9, 24'h2, 1'b1, 0, 5, 8'h1F, 32'd5);

    // 1030 bytes starting at PSN 0xFFFFFF: PSN wraps, LAST has 6 data bytes
    g_use_pat = 1'b1;
    start(32'd1030, 24'hFFFFFF, 24'h3);
    recv_packet(0, 1'b0);
    chk_pkt("wrap_first", 8'h06, 1064, 24'hFFFFFF, 24'h3, 1'b0, 0, 132, 8'hFF, 32'd1030);
    recv_packet(0, 1'b0);
    chk_pkt("wrap_last", 8'h08, 30, 24'h000000, 24'h3, 1'b1, 1024, 3, 8'h3F, 32'd0);
    g_use_pat = 1'b0;

    // Reset mid-payload, then restart from rem_psn
    start(32'd4096, 24'd55, 24'h4);
    m_udp_hdr_ready = 1'b1;
    @(posedge clk); #1;
    m_udp_hdr_ready = 1'b0;
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_payload_tvalid", tvalid, 1'b1);
    rst = 1'b1;
    #2;
    check("async_rst_tvalid", tvalid, 1'b0);
    check("async_rst_hdr_valid", m_udp_hdr_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start(32'd2048, 24'd55, 24'h4);
    recv_packet(0, 1'b0);
    chk_pkt("post_rst_first", 8'h06, 1064, 24'd55, 24'h4, 1'b0, 0, 132, 8'hFF, 32'd2048);
    recv_packet(0, 1'b0);
    chk_pkt("post_rst_last", 8'h08, 1048, 24'd56, 24'h4, 1'b1, 1024, 130, 8'hFF, 32'd0);
    check("busy_end", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
